// File: rtl/alu_exec_unit.sv
// Single-issue integer ALU with a valid/ready handshake on both sides.
// Add/sub/logic ops finish in one cycle; mul and div iterate one bit per cycle.
module alu_exec_unit #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int RD_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_LINE-1:0] opcode,
  input  logic [N-1:0]        rs1_val,
  input  logic [N-1:0]        rs2_val,
  input  logic [RD_W-1:0]     rd_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        result,
  output logic [RD_W-1:0]     rd_out,
  output logic                div_zero,
  output logic                illegal_op
);

  localparam logic [SEL_LINE-1:0] OP_ADD = SEL_LINE'(0);
  localparam logic [SEL_LINE-1:0] OP_SUB = SEL_LINE'(1);
  localparam logic [SEL_LINE-1:0] OP_MUL = SEL_LINE'(2);
  localparam logic [SEL_LINE-1:0] OP_DIV = SEL_LINE'(3);
  localparam logic [SEL_LINE-1:0] OP_AND = SEL_LINE'(4);
  localparam logic [SEL_LINE-1:0] OP_OR  = SEL_LINE'(5);
  localparam logic [SEL_LINE-1:0] OP_XOR = SEL_LINE'(6);
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [N-1:0]      a_reg, b_reg, acc_reg;
  logic [N-1:0]      a_next, b_next, acc_next;
  logic [CNT_W-1:0]  count_reg;
  logic              is_div_reg;
  logic [RD_W-1:0]   rd_reg;
  logic [N-1:0]      result_reg;
  logic              dz_reg, ill_reg;

  logic              accept, last_iter;
  logic [N-1:0]      fast_result;
  logic              fast_dz, fast_ill, long_op;
  logic [N:0]        shifted, diff;

  assign in_ready   = (state_reg == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_reg == DONE);
  assign result     = result_reg;
  assign rd_out     = rd_reg;
  assign div_zero   = dz_reg && out_valid;
  assign illegal_op = ill_reg && out_valid;
  assign last_iter  = (count_reg == CNT_W'(N - 1));

  // Single-cycle results, plus the decision whether the op needs the iterative path
  always_comb begin
    fast_result = '0;
    fast_dz     = 1'b0;
    fast_ill    = 1'b0;
    long_op     = 1'b0;
    case (opcode)
      OP_ADD: fast_result = rs1_val + rs2_val;
      OP_SUB: fast_result = rs1_val - rs2_val;
      OP_MUL: long_op = 1'b1;
      OP_DIV: begin
        if (rs2_val == '0) begin
          fast_result = '1;
          fast_dz     = 1'b1;
        end else begin
          long_op = 1'b1;
        end
      end
      OP_AND: fast_result = rs1_val & rs2_val;
      OP_OR:  fast_result = rs1_val | rs2_val;
      OP_XOR: fast_result = rs1_val ^ rs2_val;
      default: fast_ill = 1'b1;
    endcase
  end

  // One iteration step. Div: acc is the partial remainder, a shifts out dividend
  // bits from the top and shifts in quotient bits at the bottom.
  // Mul: acc is the running product, a is the shifted multiplicand, b the multiplier.
  always_comb begin
    shifted  = {acc_reg, a_reg[N-1]};
    diff     = shifted - {1'b0, b_reg};
    a_next   = a_reg;
    b_next   = b_reg;
    acc_next = acc_reg;
    if (is_div_reg) begin
      if (!diff[N]) begin
        acc_next = diff[N-1:0];
        a_next   = {a_reg[N-2:0], 1'b1};
      end else begin
        acc_next = shifted[N-1:0];
        a_next   = {a_reg[N-2:0], 1'b0};
      end
    end else begin
      acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
      a_next   = a_reg << 1;
      b_next   = b_reg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = long_op ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      is_div_reg <= 1'b0;
      rd_reg     <= '0;
      result_reg <= '0;
      dz_reg     <= 1'b0;
      ill_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg      <= rs1_val;
            b_reg      <= rs2_val;
            acc_reg    <= '0;
            count_reg  <= '0;
            is_div_reg <= (opcode == OP_DIV);
            rd_reg     <= rd_addr;
            dz_reg     <= fast_dz;
            ill_reg    <= fast_ill;
            if (!long_op) result_reg <= fast_result;
          end
        end
        BUSY: begin
          a_reg     <= a_next;
          b_reg     <= b_next;
          acc_reg   <= acc_next;
          count_reg <= count_reg + CNT_W'(1);
          if (last_iter) result_reg <= is_div_reg ? a_next : acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a cycle-level reference model checks every
// cycle, and each directed vector also checks hand-computed literals.
module tb_alu_exec_unit;
  localparam int N = 16;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    opcode;
  logic [N-1:0]  rs1_val, rs2_val, result;
  logic [3:0]    rd_addr, rd_out;
  logic          div_zero, illegal_op;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.N(N), .SEL_LINE(4), .RD_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .div_zero(div_zero), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pending-latency counter plus arithmetic on captured operands
  logic         m_valid = 1'b0, m_busy = 1'b0, m_clean = 1'b1;
  int           m_wait = 0;
  logic [N-1:0] e_res = '0;
  logic [3:0]   e_rd = '0;
  logic         e_dz = 1'b0, e_ill = 1'b0;
  logic         exp_ready;

  always @(negedge clk) begin
    logic [31:0] prod;
    exp_ready = !rst && !m_busy && !m_valid;
    chk("m_in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid || m_clean) begin
      chk("m_result", {16'b0, result}, {16'b0, e_res});
      chk("m_rd_out", {28'b0, rd_out}, {28'b0, e_rd});
    end
    chk("m_div_zero", {31'b0, div_zero}, {31'b0, m_valid && e_dz});
    chk("m_illegal", {31'b0, illegal_op}, {31'b0, m_valid && e_ill});
    if (rst) begin
      m_valid = 0; m_busy = 0; m_wait = 0; m_clean = 1;
      e_res = '0; e_rd = '0; e_dz = 0; e_ill = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin m_busy = 0; m_valid = 1; end
    end else if (in_valid) begin
      m_clean = 0;
      e_rd = rd_addr; e_dz = 0; e_ill = 0;
      prod = rs1_val * rs2_val;
      case (opcode)
        4'd0: e_res = rs1_val + rs2_val;
        4'd1: e_res = rs1_val - rs2_val;
        4'd2: e_res = prod[N-1:0];
        4'd3: if (rs2_val == 0) begin e_res = '1; e_dz = 1; end
              else e_res = rs1_val / rs2_val;
        4'd4: e_res = rs1_val & rs2_val;
        4'd5: e_res = rs1_val | rs2_val;
        4'd6: e_res = rs1_val ^ rs2_val;
        default: begin e_res = '0; e_ill = 1; end
      endcase
      if (opcode == 4'd2 || (opcode == 4'd3 && rs2_val != 0)) begin
        m_busy = 1; m_wait = N;
      end else begin
        m_valid = 1;
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end
  endtask

  // Offer one op, check latency, result and flags against literals, then consume
  task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] rd, input int hold,
                        input logic [N-1:0] exp_res, input int exp_lat,
                        input logic exp_dz, input logic exp_ill);
    int lat = 0;
    wait_ready(name);
    @(posedge clk); #1;
    in_valid = 1; opcode = op; rs1_val = a; rs2_val = b; rd_addr = rd;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 0; opcode = 4'd1; rs1_val = 16'hDEAD; rs2_val = 16'hBEEF; rd_addr = 4'hF;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, {16'b0, result}, {16'b0, exp_res});
    chk({name, "_rd"}, {28'b0, rd_out}, {28'b0, rd});
    chk({name, "_div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
    chk({name, "_illegal"}, {31'b0, illegal_op}, {31'b0, exp_ill});
    $display("op %s a=%h b=%h rd=%0d -> result=%h lat=%0d", name, a, b, rd, result, lat);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk({name, "_hold_result"}, {16'b0, result}, {16'b0, exp_res});
        chk({name, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
      end
      @(posedge clk); #1 out_ready = 1;
      @(negedge clk);
      chk({name, "_consume_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_consume_ready"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      chk({name, "_idle_after"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    rst = 1; in_valid = 1; out_ready = 1; opcode = 4'd0;
    rs1_val = 16'h1111; rs2_val = 16'h2222; rd_addr = 4'h7;
    repeat (3) @(posedge clk);
    #1 rst = 0; in_valid = 0;
    @(negedge clk);
    chk("reset_result", {16'b0, result}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);

    run_op("add_wrap", 4'd0, 16'hFFFF, 16'h0002, 4'd3, 0, 16'h0001, 1, 0, 0);
    run_op("mul",      4'd2, 16'h0012, 16'h0034, 4'd4, 0, 16'h03A8, 17, 0, 0);
    run_op("div",      4'd3, 16'h0064, 16'h0007, 4'd2, 0, 16'h000E, 17, 0, 0);
    run_op("div_zero", 4'd3, 16'h0064, 16'h0000, 4'd6, 0, 16'hFFFF, 1, 1, 0);
    run_op("xor_hold", 4'd6, 16'hAAAA, 16'h0F0F, 4'd1, 5, 16'hA5A5, 1, 0, 0);
    run_op("illegal",  4'd9, 16'h1234, 16'h5678, 4'd5, 0, 16'h0000, 1, 0, 1);
    run_op("sub_wrap", 4'd1, 16'h0003, 16'h0005, 4'd8, 0, 16'hFFFE, 1, 0, 0);
    run_op("and",      4'd4, 16'hF0F0, 16'h3CC3, 4'd9, 0, 16'h30C0, 1, 0, 0);
    run_op("or",       4'd5, 16'hF0F0, 16'h0F00, 4'd10, 0, 16'hFFF0, 1, 0, 0);
    run_op("mul_max",  4'd2, 16'hFFFF, 16'hFFFF, 4'd11, 2, 16'h0001, 17, 0, 0);
    run_op("div_one",  4'd3, 16'hFFFF, 16'h0001, 4'd12, 0, 16'hFFFF, 17, 0, 0);
    run_op("div_small",4'd3, 16'h0005, 16'h0009, 4'd13, 0, 16'h0000, 17, 0, 0);

    // Reset during the eighth BUSY cycle of a divide, with in_valid also high
    wait_ready("rst_busy");
    @(posedge clk); #1;
    in_valid = 1; opcode = 4'd3; rs1_val = 16'h0064; rs2_val = 16'h0007; rd_addr = 4'd14;
    @(posedge clk); #1 in_valid = 0;
    repeat (7) @(posedge clk);
    #1 rst = 1; in_valid = 1; opcode = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst_busy_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy_result", {16'b0, result}, 32'd0);
    repeat (25) begin
      @(negedge clk);
      chk("rst_busy_no_valid", {31'b0, out_valid}, 32'd0);
    end
    $display("op rst_busy -> out_valid stayed low, in_ready=%0d", in_ready);

    // Reset while an unconsumed result is presented
    out_ready = 0;
    @(posedge clk); #1;
    in_valid = 1; opcode = 4'd0; rs1_val = 16'h0001; rs2_val = 16'h0001; rd_addr = 4'd2;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("rst_done_valid_before", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rst_done_valid_after", {31'b0, out_valid}, 32'd0);
    chk("rst_done_rd", {28'b0, rd_out}, 32'd0);
    $display("op rst_done -> out_valid=%0d rd_out=%0d", out_valid, rd_out);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
